// File: rtl/gate_pattern_checker.sv
// Self-running exhaustive stimulus/response checker for a single-output logic gate.
// Walks stim through every input value, holds each DWELL clocks, samples dut_y on the last one.
module gate_pattern_checker #(
    parameter int N_IN    = 2,
    parameter int DWELL   = 4,
    parameter int GATE_OP = 0,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_fail,
    output logic              fail_seen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t             r_state;
    state_t             w_next;
    logic [N_IN-1:0]    r_stim;
    logic [7:0]         r_dwell_cnt;
    logic [ERR_W-1:0]   r_err_count;
    logic [N_IN-1:0]    r_first_fail;
    logic               r_fail_seen;
    logic               r_pass;

    logic               w_exp;
    logic               w_sample;
    logic               w_last_pat;
    logic               w_mismatch;

    always_comb begin
        case (GATE_OP)
            1:       w_exp = |r_stim;
            2:       w_exp = ~&r_stim;
            3:       w_exp = ~|r_stim;
            4:       w_exp = ^r_stim;
            5:       w_exp = ~^r_stim;
            default: w_exp = &r_stim;
        endcase
    end

    assign w_sample   = (r_state == S_DRIVE) && (r_dwell_cnt == DWELL_LAST);
    assign w_last_pat = (r_stim == {N_IN{1'b1}});
    assign w_mismatch = w_sample && (dut_y != w_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: w_next takes its hold value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRIVE;
            S_DRIVE: if (w_sample && w_last_pat) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stim       <= '0;
            r_dwell_cnt  <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stim       <= '0;
                        r_dwell_cnt  <= '0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                        r_fail_seen  <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_dwell_cnt <= r_dwell_cnt + 8'd1;
                    if (w_mismatch) begin
                        if (r_err_count != {ERR_W{1'b1}})
                            r_err_count <= r_err_count + ERR_W'(1);
                        if (!r_fail_seen) begin
                            r_first_fail <= r_stim;
                            r_fail_seen  <= 1'b1;
                        end
                    end
                    if (w_sample) begin
                        // The final pattern holds in stim until the next start.
                        if (w_last_pat) begin
                            r_pass <= !(r_fail_seen || w_mismatch);
                        end else begin
                            r_stim      <= r_stim + N_IN'(1);
                            r_dwell_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim       = r_stim;
    assign busy       = (r_state == S_DRIVE);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign fail_seen  = r_fail_seen;

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Bench for gate_pattern_checker: three parameterisations checked every cycle against a
// time-indexed reference model, plus directed runs with hand-computed expectations.
module tb_gate_pattern_checker;

    typedef struct {
        int t;      // cycles since the run began; -1 when idle
        int stim;
        int err;
        int first;
        int seen;
        int pass;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;   // 0 correct gate, 1 tied 0, 2 tied 1, 3 AND gate, 4 random
    int   rnd = 0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // a: N_IN=2 DWELL=4 AND ERR_W=8; b: N_IN=2 DWELL=1 XOR ERR_W=8; c: N_IN=3 DWELL=2 NOR ERR_W=1
    logic [1:0] stim_a, first_a, stim_b, first_b;
    logic [2:0] stim_c, first_c;
    logic [7:0] err_a, err_b;
    logic [0:0] err_c;
    logic busy_a, done_a, pass_a, seen_a, y_a;
    logic busy_b, done_b, pass_b, seen_b, y_b;
    logic busy_c, done_c, pass_c, seen_c, y_c;

    function automatic bit exp_of(input int op, input int idx, input int n);
        bit a_v = (idx == (1 << n) - 1);
        bit o_v = (idx != 0);
        bit x_v = ($countones(idx) % 2) == 1;
        case (op)
            1: return o_v;
            2: return !a_v;
            3: return !o_v;
            4: return x_v;
            5: return !x_v;
            default: return a_v;
        endcase
    endfunction

    function automatic bit y_of(input int md, input int s, input int r, input int n, input int op);
        case (md)
            0: return exp_of(op, s, n);
            1: return 1'b0;
            2: return 1'b1;
            3: return s == (1 << n) - 1;
            default: return r[0];
        endcase
    endfunction

    function automatic model_t m_reset();
        model_t q;
        q.t = -1; q.stim = 0; q.err = 0; q.first = 0; q.seen = 0; q.pass = 0;
        return q;
    endfunction

    function automatic model_t m_step(input model_t m, input bit st, input int md, input int r,
                                      input int n, input int d, input int op, input int errw);
        model_t q = m;
        int p = 1 << n;
        int maxe = (1 << errw) - 1;
        int idx;
        if (m.t < 0) begin
            if (st) begin
                q.t = 0; q.stim = 0; q.err = 0; q.first = 0; q.seen = 0; q.pass = 0;
            end
        end else if (m.t < p * d) begin
            idx = m.t / d;
            if (m.t % d == d - 1) begin
                if (y_of(md, idx, r, n, op) != exp_of(op, idx, n)) begin
                    if (q.err < maxe) q.err = q.err + 1;
                    if (q.seen == 0) begin
                        q.seen = 1;
                        q.first = idx;
                    end
                end
                if (idx == p - 1) q.pass = (q.seen == 0) ? 1 : 0;
            end
            q.t = m.t + 1;
            if (q.t < p * d) q.stim = q.t / d;
        end else begin
            q.t = -1;
        end
        return q;
    endfunction

    assign y_a = y_of(mode, int'(stim_a), rnd, 2, 0);
    assign y_b = y_of(mode, int'(stim_b), rnd, 2, 4);
    assign y_c = y_of(mode, int'(stim_c), rnd, 3, 3);

    gate_pattern_checker #(.N_IN(2), .DWELL(4), .GATE_OP(0), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stim(stim_a), .dut_y(y_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(first_a), .fail_seen(seen_a));
    gate_pattern_checker #(.N_IN(2), .DWELL(1), .GATE_OP(4), .ERR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stim(stim_b), .dut_y(y_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(first_b), .fail_seen(seen_b));
    gate_pattern_checker #(.N_IN(3), .DWELL(2), .GATE_OP(3), .ERR_W(1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .stim(stim_c), .dut_y(y_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail(first_c), .fail_seen(seen_c));

    model_t m_a, m_b, m_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= m_reset();
            m_b <= m_reset();
            m_c <= m_reset();
        end else begin
            m_a <= m_step(m_a, start, mode, rnd, 2, 4, 0, 8);
            m_b <= m_step(m_b, start, mode, rnd, 2, 1, 4, 8);
            m_c <= m_step(m_c, start, mode, rnd, 3, 2, 3, 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cmp(input string tag, input model_t m, input int n, input int d,
                       input logic [31:0] s, input logic [31:0] bz, input logic [31:0] dn,
                       input logic [31:0] ps, input logic [31:0] er, input logic [31:0] ff,
                       input logic [31:0] fs);
        int len = (1 << n) * d;
        check({tag, "_stim"}, s, m.stim);
        check({tag, "_busy"}, bz, (m.t >= 0 && m.t < len) ? 1 : 0);
        check({tag, "_done"}, dn, (m.t == len) ? 1 : 0);
        check({tag, "_pass"}, ps, m.pass);
        check({tag, "_err_count"}, er, m.err);
        check({tag, "_first_fail"}, ff, m.first);
        check({tag, "_fail_seen"}, fs, m.seen);
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            cmp("a", m_a, 2, 4, 32'(stim_a), 32'(busy_a), 32'(done_a), 32'(pass_a),
                32'(err_a), 32'(first_a), 32'(seen_a));
            cmp("b", m_b, 2, 1, 32'(stim_b), 32'(busy_b), 32'(done_b), 32'(pass_b),
                32'(err_b), 32'(first_b), 32'(seen_b));
            cmp("c", m_c, 3, 2, 32'(stim_c), 32'(busy_c), 32'(done_c), 32'(pass_c),
                32'(err_c), 32'(first_c), 32'(seen_c));
        end
    end

    // Starts a run on the edge after the call; j counts cycles after that edge.
    task automatic run_measure(input int md, input bit hold, input bit repulse,
                               output int first_busy, output int last_busy,
                               output int done_at, output int next_busy);
        first_busy = -1; last_busy = -1; done_at = -1; next_busy = -1;
        mode = md;
        start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            #1;
            start = hold || (repulse && j == 5);
            if (busy_a && done_at < 0 && first_busy < 0) first_busy = j;
            if (busy_a && done_at < 0) last_busy = j;
            if (done_a && done_at < 0) done_at = j;
            if (busy_a && done_at >= 0 && next_busy < 0) next_busy = j;
            if (done_at >= 0 && (!hold || next_busy >= 0)) break;
        end
        start = 1'b0;
        if (done_at < 0) check("run_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int j = 0; j < 100 && !idle; j++) begin
            @(negedge clk);
            #1;
            idle = !(busy_a || done_a || busy_b || done_b || busy_c || done_c);
        end
        @(negedge clk);
        #1;
        if (!idle) check("idle_timeout", 0, 1);
    endtask

    int fb, lb, da, nb;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_stim", 32'(stim_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_err", 32'(err_a), 0);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Correct gates: timing and clean pass
        run_measure(0, 1'b0, 1'b0, fb, lb, da, nb);
        check("t1_first_busy", fb, 1);
        check("t1_last_busy", lb, 16);
        check("t1_done_at", da, 17);
        wait_idle();
        check("t1_pass_a", 32'(pass_a), 1);
        check("t1_err_a", 32'(err_a), 0);
        check("t1_seen_a", 32'(seen_a), 0);
        check("t1_pass_b", 32'(pass_b), 1);
        check("t1_pass_c", 32'(pass_c), 1);

        // Output tied low
        run_measure(1, 1'b0, 1'b0, fb, lb, da, nb);
        wait_idle();
        check("t2_err_a", 32'(err_a), 1);
        check("t2_first_a", 32'(first_a), 3);
        check("t2_seen_a", 32'(seen_a), 1);
        check("t2_pass_a", 32'(pass_a), 0);
        check("t2_err_b", 32'(err_b), 2);
        check("t2_first_b", 32'(first_b), 1);
        check("t2_first_c", 32'(first_c), 0);

        // Output tied high; c saturates its 1-bit counter
        run_measure(2, 1'b0, 1'b0, fb, lb, da, nb);
        wait_idle();
        check("t3_err_a", 32'(err_a), 3);
        check("t3_first_a", 32'(first_a), 0);
        check("t3_pass_a", 32'(pass_a), 0);
        check("t3_err_c_sat", 32'(err_c), 1);
        check("t3_first_c", 32'(first_c), 1);

        // An AND gate against the XOR expectation
        run_measure(3, 1'b0, 1'b0, fb, lb, da, nb);
        wait_idle();
        check("t6_err_b", 32'(err_b), 3);
        check("t6_first_b", 32'(first_b), 1);
        check("t6_pass_b", 32'(pass_b), 0);
        check("t6_pass_a", 32'(pass_a), 1);

        // start re-pulsed mid-run is ignored
        run_measure(0, 1'b0, 1'b1, fb, lb, da, nb);
        check("t5_repulse_last_busy", lb, 16);
        check("t5_repulse_done_at", da, 17);
        wait_idle();

        // start held high: back-to-back runs
        run_measure(0, 1'b1, 1'b0, fb, lb, da, nb);
        check("t5_hold_done_at", da, 17);
        check("t5_hold_next_busy", nb, 19);
        wait_idle();

        // Asynchronous reset mid-run
        mode = 2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 30 && stim_a != 2'd2; j++) @(negedge clk);
        check("t4_reached_stim2", 32'(stim_a), 2);
        #2 rst = 1'b1;
        #1;
        check("t4_stim", 32'(stim_a), 0);
        check("t4_busy", 32'(busy_a), 0);
        check("t4_done", 32'(done_a), 0);
        check("t4_pass", 32'(pass_a), 0);
        check("t4_err", 32'(err_a), 0);
        check("t4_first", 32'(first_a), 0);
        check("t4_seen", 32'(seen_a), 0);
        check("t4_busy_c", 32'(busy_c), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_measure(0, 1'b0, 1'b0, fb, lb, da, nb);
        check("t4_rerun_first_busy", fb, 1);
        wait_idle();
        check("t4_rerun_pass", 32'(pass_a), 1);
        check("t4_rerun_err", 32'(err_a), 0);

        // Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            rnd = int'($urandom_range(0, 1));
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) mode = int'($urandom_range(0, 4));
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        start = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
